// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU definitions for the fetch sequencer: state encoding, default
// step/halt opcode, and instruction field layout.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_t;

    localparam int unsigned STEP_DEFAULT    = 4;
    localparam logic [7:0]  HALT_OP_DEFAULT = 8'hFF;

    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned ARG1_LSB   = 8;
    localparam int unsigned ARG2_LSB   = 16;
    localparam int unsigned RESULT_LSB = 24;

    function automatic logic [31:0] pack_instr(
        input logic [7:0] opcode,
        input logic [7:0] arg1,
        input logic [7:0] arg2,
        input logic [7:0] result
    );
        logic [31:0] word;
        word = '0;
        word[OPCODE_LSB +: 8] = opcode;
        word[ARG1_LSB   +: 8] = arg1;
        word[ARG2_LSB   +: 8] = arg2;
        word[RESULT_LSB +: 8] = result;
        return word;
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer: reads four bytes per instruction from
// program RAM, strobes exec for one cycle, then advances or branches pc.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned STEP    = STEP_DEFAULT,
    parameter logic [7:0]  HALT_OP = HALT_OP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        step,
    output logic [7:0]  mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    input  logic        mem_ready,
    input  logic        jump_valid,
    input  logic [7:0]  jump_addr,
    output logic [7:0]  pc,
    output logic [31:0] instr,
    output logic        exec,
    output logic        busy,
    output logic        halted
);

    localparam logic [7:0] STEP_INC = 8'(STEP);

    state_t      state;
    state_t      state_next;
    logic [1:0]  idx;
    logic [23:0] buffer;
    logic        capture;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_rd     = 1'b0;
        exec       = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run || step) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_rd  = 1'b1;
                busy    = 1'b1;
                capture = mem_ready;
                if (mem_ready && idx == 2'd3) begin
                    state_next = (buffer[OPCODE_LSB +: 8] == HALT_OP) ? ST_HALT : ST_EXEC;
                end
            end
            ST_EXEC: begin
                exec       = 1'b1;
                busy       = 1'b1;
                state_next = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // idx is held at 0 outside FETCH, so this is simply pc in other states.
    assign mem_addr = pc + {6'b0, idx};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= '0;
            idx    <= '0;
            buffer <= '0;
            instr  <= '0;
        end else begin
            if (capture) begin
                idx <= idx + 2'd1;
                // Byte 3 goes straight into instr alongside the buffered bytes.
                case (idx)
                    2'd0: buffer[7:0]   <= mem_data;
                    2'd1: buffer[15:8]  <= mem_data;
                    2'd2: buffer[23:16] <= mem_data;
                    default: instr <= pack_instr(buffer[7:0], buffer[15:8],
                                                 buffer[23:16], mem_data);
                endcase
            end
            if (state == ST_EXEC) begin
                pc  <= jump_valid ? {jump_addr[7:2], 2'b00} : pc + STEP_INC;
                idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: instruction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        mem_ready = 1'b1;
    logic        jump_valid = 1'b0;
    logic [7:0]  jump_addr = 8'h00;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic [7:0]  pc;
    logic [31:0] instr;
    logic        exec;
    logic        busy;
    logic        halted;

    logic [7:0]  ram [256];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    assign mem_data = ram[mem_addr];

    fetch_sequencer #(.STEP(4), .HALT_OP(8'hFF)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .step       (step),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .jump_valid (jump_valid),
        .jump_addr  (jump_addr),
        .pc         (pc),
        .instr      (instr),
        .exec       (exec),
        .busy       (busy),
        .halted     (halted)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Instruction-level model: fetching gathers four bytes from pc onward,
    // then either executes once or halts for good.
    bit          m_fetching = 1'b0;
    bit          m_exec = 1'b0;
    bit          m_halted = 1'b0;
    int unsigned m_n = 0;
    logic [7:0]  m_pc = 8'h00;
    logic [31:0] m_instr = '0;
    logic [7:0]  m_byte [4];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_fetching = 1'b0;
            m_exec     = 1'b0;
            m_halted   = 1'b0;
            m_n        = 0;
            m_pc       = 8'h00;
            m_instr    = '0;
        end else if (m_fetching) begin
            if (mem_ready) begin
                m_byte[m_n] = ram[8'(m_pc + m_n)];
                if (m_n == 3) begin
                    m_instr    = {m_byte[3], m_byte[2], m_byte[1], m_byte[0]};
                    m_fetching = 1'b0;
                    m_n        = 0;
                    if (m_byte[0] == 8'hFF) m_halted = 1'b1;
                    else                    m_exec   = 1'b1;
                end else begin
                    m_n++;
                end
            end
        end else if (m_exec) begin
            m_exec     = 1'b0;
            m_pc       = jump_valid ? (jump_addr & 8'hFC) : m_pc + 8'd4;
            m_fetching = run;
        end else if (!m_halted && (run || step)) begin
            m_fetching = 1'b1;
        end
    end

    always @(negedge clk) begin
        check("outputs", {mem_rd, exec, busy, halted, pc, instr},
              {m_fetching, m_exec, m_fetching | m_exec, m_halted, m_pc, m_instr});
        if (m_fetching || !rst) check("mem_addr", mem_addr, 8'(m_pc + m_n));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_exec(input int unsigned limit, output int unsigned n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!exec && n < limit);
        if (!exec) check("exec_timeout", exec, 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        run = 1'b0;
        step = 1'b0;
        jump_valid = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 256; i++) ram[i] = 8'(i) & 8'h7F;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned n;
        int unsigned ex;

        do_reset();
        check("rst_pc", pc, 8'h00);
        check("rst_busy", busy, 0);

        // Basic fetch and three back-to-back instructions
        ram[0] = 8'h01; ram[1] = 8'h02; ram[2] = 8'h03; ram[3] = 8'h04;
        run = 1'b1;
        wait_exec(20, n);
        check("first_latency", n, 5);
        check("first_instr", instr, 32'h04030201);
        check("exec_pc0", pc, 8'h00);
        wait_exec(20, n);
        check("b2b_gap1", n, 5);
        check("exec_pc4", pc, 8'h04);
        wait_exec(20, n);
        check("b2b_gap2", n, 5);
        check("exec_pc8", pc, 8'h08);
        run = 1'b0;
        tick();
        check("pc_after_3", pc, 8'h0C);
        check("idle_after_3", busy, 0);

        // Taken branch, ignored branch outside EXEC, run dropped mid-fetch
        do_reset();
        run = 1'b1;
        wait_exec(20, n);
        jump_valid = 1'b1;
        jump_addr = 8'h13;
        tick();
        jump_valid = 1'b0;
        check("jump_fetch_addr", mem_addr, 8'h10);
        check("jump_pc", pc, 8'h10);
        jump_valid = 1'b1;
        jump_addr = 8'h40;
        tick();
        tick();
        jump_valid = 1'b0;
        run = 1'b0;
        wait_exec(20, n);
        check("run_drop_finish", n, 2);
        check("jump_instr", instr, 32'h13121110);
        tick();
        check("run_drop_pc", pc, 8'h14);
        tick();
        check("run_drop_idle", busy, 0);

        // Memory stall on byte 2, then asynchronous reset mid-fetch
        do_reset();
        ram[0] = 8'hA1; ram[1] = 8'hB2; ram[2] = 8'hC3; ram[3] = 8'hD4;
        run = 1'b1;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_addr", mem_addr, 8'h02);
            tick();
        end
        mem_ready = 1'b1;
        wait_exec(20, n);
        check("stall_latency", n + 6, 8);
        check("stall_instr", instr, 32'hD4C3B2A1);
        tick();
        tick();
        #2 rst = 1'b0;
        #1 check("async_rst_fetch", {busy, mem_rd, mem_addr, pc}, 0);

        // Halt opcode at address 8
        do_reset();
        ram[8] = 8'hFF;
        run = 1'b1;
        ex = 0;
        for (int i = 0; i < 30 && !halted; i++) begin
            tick();
            if (exec) ex++;
        end
        check("halted", halted, 1);
        check("halt_pc", pc, 8'h08);
        check("halt_execs", ex, 2);
        step = 1'b1;
        tick();
        step = 1'b0;
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (exec) ex++;
        end
        check("halt_sticky", halted, 1);
        check("halt_no_exec", ex, 2);
        #3 rst = 1'b0;
        #1 check("async_rst_halt", {halted, busy, pc}, 0);

        // Single step, step ignored while busy, pc wrap at FC
        do_reset();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        ex = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (exec) ex++;
        end
        check("step_one_exec", ex, 1);
        check("step_pc", pc, 8'h04);
        check("step_idle", busy, 0);
        run = 1'b1;
        wait_exec(20, n);
        jump_valid = 1'b1;
        jump_addr = 8'hFE;
        run = 1'b0;
        tick();
        jump_valid = 1'b0;
        check("wrap_pc_fc", pc, 8'hFC);
        step = 1'b1;
        tick();
        step = 1'b0;
        ex = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (exec) ex++;
        end
        check("wrap_one_exec", ex, 1);
        check("wrap_instr", instr, 32'h7F7E7D7C);
        check("wrap_pc_00", pc, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
